effects_pipeline: RTL and testbench
===================================

Name: effects_pipeline

Overview:
- Guitar-effects datapath between the ADC front end (12-bit signed samples) and the DAC/output formatter.
- Applies a programmable fixed-point gain, then symmetric hard clipping (distortion), and emits the result sign-extended to 32 bits.
- Fully pipelined: one sample accepted per clock while valid is high.

Parameters:
- SAMPLE_W, 12, input/processing sample width (signed two's complement)
- GAIN_W, 11, gain word width (unsigned)
- GAIN_FRAC, 5, fractional bits of gain (Q6.5; 32 = unity)
- CLIP_LEVEL, 2047, symmetric clip magnitude; must be ≤ 2^(SAMPLE_W-1)-1
- OUT_W, 32, output width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  sample_in/gain_value qualify; pipeline advances only when high
- gain_value  in  GAIN_W  unsigned gain, Q6.5
- sample_in  in  SAMPLE_W  signed input sample
- sample_out  out  OUT_W  processed sample, signed, sign-extended from SAMPLE_W

Behaviour:
- Single clock domain. Reset is synchronous and active-high. rst has priority over valid. On rst, all pipeline registers and sample_out go to 0.
- Stage 1 (capture): when valid=1, register sample_in and gain_value together. A gain change applies starting with the sample presented alongside it.
- Stage 2 (gain):
  - product = signed(sample) × zero-extended gain, 24-bit signed (SAMPLE_W+GAIN_W+1), no overflow possible.
  - scaled = product >>> GAIN_FRAC (arithmetic shift, floor toward −inf).
  - Registered.
- Stage 3 (clip): if scaled > CLIP_LEVEL, result = +CLIP_LEVEL; if scaled < −CLIP_LEVEL, result = −CLIP_LEVEL; else result = scaled[SAMPLE_W-1:0]. Registered.
- Output: sample_out = result sign-extended to OUT_W, driven directly from the stage-3 register.
- Latency: 3 valid-qualified clock edges from sample capture to sample_out update.
- valid=0: every stage holds its contents, sample_out holds. No bubbles are inserted, and no output-valid is generated. Downstream samples sample_out once per input sample period.
- Boundaries:
  - gain_value=0 → output 0.
  - sample_in=−2048 at unity gain with default CLIP_LEVEL → −2047 (symmetric clip).
  - Maximum gain 2047 (~63.97×) saturates any |sample| ≥ 33.
  - rst mid-stream flushes all stages. The first post-reset output appears 3 valid edges after reset deasserts.
- No internal state beyond the pipeline registers. The block is purely combinational-per-stage.

Decomposition:
- Package effects_pkg:
  - typedef sample_t (logic signed [11:0])
  - typedef gain_t (logic [10:0])
  - constants GAIN_FRAC=5, GAIN_UNITY=32, CLIP_LEVEL_DEFAULT=2047
- Sub-module effects_gain_clip: combinational multiply/shift/saturate function used by stages 2–3. The top level holds the registers, valid gating and output extension.

Test Plan:
- rst=1 for 2 cycles, then valid=1, gain=32, sample_in=100 → sample_out=0 during reset, 100 (0x00000064) 3 edges after capture.
- gain=64, sample_in=1500 → 2047; sample_in=−1500 → −2047 (0xFFFFF801); sample_in=−2048, gain=32 → −2047.
- gain=16, sample_in=−3 → −2 (floor of −1.5); sample_in=3 → 1; gain=0, sample_in=1234 → 0.
- Stream 0,1,2,3… at gain 32 with valid high, then valid=0 for 5 cycles mid-stream → outputs follow input with latency 3, hold unchanged while valid=0, resume without loss or duplication.
- Gain switch 32→96 between consecutive samples 500,500 → outputs 500 then 1500, with no mixing.
- rst asserted mid-stream with full pipeline → sample_out=0 on the next edge, and nothing stale emerges afterwards.

Source files
------------

// File: rtl/effects_pkg.sv
// Shared types and default constants for the guitar-effects gain/clip datapath.
package effects_pkg;

  localparam int SAMPLE_BITS        = 12;
  localparam int GAIN_BITS          = 11;
  localparam int GAIN_FRAC          = 5;
  localparam int GAIN_UNITY         = 32;
  localparam int CLIP_LEVEL_DEFAULT = 2047;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;
  typedef logic        [GAIN_BITS-1:0]   gain_t;

endpackage

// File: rtl/effects_gain_clip.sv
// Combinational datapath for the gain stage (multiply, arithmetic shift) and the
// symmetric hard-clip stage; the caller supplies and registers between them.
module effects_gain_clip
  import effects_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_BITS,
  parameter int GAIN_W     = GAIN_BITS,
  parameter int GAIN_FRAC  = effects_pkg::GAIN_FRAC,
  parameter int CLIP_LEVEL = CLIP_LEVEL_DEFAULT
) (
  input  logic [SAMPLE_W-1:0]             sample,
  input  logic [GAIN_W-1:0]               gain,
  input  logic [SAMPLE_W+GAIN_W:0]        scaled_in,
  output logic [SAMPLE_W+GAIN_W:0]        scaled,
  output logic [SAMPLE_W-1:0]             clipped
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam logic signed [PROD_W-1:0] CLIP_POS = PROD_W'(CLIP_LEVEL);
  localparam logic signed [PROD_W-1:0] CLIP_NEG = -CLIP_POS;

  logic signed [PROD_W-1:0] s_ext;
  logic signed [PROD_W-1:0] g_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] scaled_s;

  // Gain is zero-extended so the product stays a signed x unsigned result.
  assign s_ext   = PROD_W'($signed(sample));
  assign g_ext   = PROD_W'({1'b0, gain});
  assign product = s_ext * g_ext;
  assign scaled  = product >>> GAIN_FRAC;

  assign scaled_s = scaled_in;

  always_comb begin
    clipped = scaled_s[SAMPLE_W-1:0];
    if (scaled_s > CLIP_POS)
      clipped = SAMPLE_W'(CLIP_LEVEL);
    else if (scaled_s < CLIP_NEG)
      clipped = SAMPLE_W'(-CLIP_LEVEL);
  end

endmodule

// File: rtl/effects_pipeline.sv
// Three-stage valid-gated effects pipeline: capture, gain, clip; output is the
// stage-3 register sign-extended to OUT_W.
module effects_pipeline
  import effects_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_BITS,
  parameter int GAIN_W     = GAIN_BITS,
  parameter int GAIN_FRAC  = effects_pkg::GAIN_FRAC,
  parameter int CLIP_LEVEL = CLIP_LEVEL_DEFAULT,
  parameter int OUT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [GAIN_W-1:0]   gain_value,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [OUT_W-1:0]    sample_out
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic [SAMPLE_W-1:0] s1_sample;
  logic [GAIN_W-1:0]   s1_gain;
  logic [PROD_W-1:0]   s2_scaled;
  logic [SAMPLE_W-1:0] s3_result;
  logic [PROD_W-1:0]   scaled_next;
  logic [SAMPLE_W-1:0] clipped_next;

  effects_gain_clip #(
    .SAMPLE_W   (SAMPLE_W),
    .GAIN_W     (GAIN_W),
    .GAIN_FRAC  (GAIN_FRAC),
    .CLIP_LEVEL (CLIP_LEVEL)
  ) u_gain_clip (
    .sample    (s1_sample),
    .gain      (s1_gain),
    .scaled_in (s2_scaled),
    .scaled    (scaled_next),
    .clipped   (clipped_next)
  );

  // All stages advance together on valid; with valid low everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sample <= '0;
      s1_gain   <= '0;
      s2_scaled <= '0;
      s3_result <= '0;
    end else if (valid) begin
      s1_sample <= sample_in;
      s1_gain   <= gain_value;
      s2_scaled <= scaled_next;
      s3_result <= clipped_next;
    end
  end

  assign sample_out = {{(OUT_W-SAMPLE_W){s3_result[SAMPLE_W-1]}}, s3_result};

endmodule

// File: tb/tb_effects_pipeline.sv
// Bench for effects_pipeline: directed boundary cases plus randomized traffic,
// checked against a floor-divide/clamp model with a 3-sample valid-edge delay.
module tb_effects_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [10:0] gain_value;
  logic [11:0] sample_in;
  logic [31:0] sample_out;

  int compared   = 0;
  int mismatched = 0;
  int hist[$];

  effects_pipeline dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .gain_value (gain_value),
    .sample_in  (sample_in),
    .sample_out (sample_out)
  );

  always #5 clk = ~clk;

  function automatic int ref_proc(int s, int g);
    int p, q;
    p = s * g;
    q = p / 32;
    if (p < 0 && (p % 32) != 0) q = q - 1;
    if (q > 2047)  q = 2047;
    if (q < -2047) q = -2047;
    return q;
  endfunction

  function automatic logic [31:0] model_out();
    if (hist.size() >= 3) return hist[hist.size()-3];
    return 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    compared++;
    assert (sample_out === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, sample_out, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input int g, input int s, input string tag);
    @(negedge clk);
    rst        = r;
    valid      = v;
    gain_value = 11'(g);
    sample_in  = 12'(s);
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else if (v) hist.push_back(ref_proc(s, g));
    check(tag, model_out());
  endtask

  int dg[10] = '{32, 64, 64, 32, 16, 16, 0, 32, 32, 32};
  int ds[10] = '{100, 1500, -1500, -2048, -3, 3, 1234, 0, 0, 0};
  logic [31:0] dlit[10] = '{32'h0, 32'h0, 32'h64, 32'h7FF, 32'hFFFFF801, 32'hFFFFF801,
                            32'hFFFFFFFE, 32'h1, 32'h0, 32'h0};

  initial begin
    rst = 1'b1; valid = 1'b0; gain_value = '0; sample_in = '0;

    step(1'b1, 1'b0, 0, 0, "reset0");
    step(1'b1, 1'b1, 32, 555, "reset1");

    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, dg[i], ds[i], "directed");
      if (i >= 2) check("directed_lit", dlit[i]);
    end

    for (int i = 0; i < 20; i++) begin
      if (i == 8)
        for (int k = 0; k < 5; k++)
          step(1'b0, 1'b0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 4095)) - 2048, "hold");
      step(1'b0, 1'b1, 32, i, "stream");
    end

    step(1'b0, 1'b1, 32, 500, "gain_sw");
    step(1'b0, 1'b1, 96, 500, "gain_sw");
    step(1'b0, 1'b1, 32, 0, "gain_sw");
    check("gain_sw_lit0", 32'd500);
    step(1'b0, 1'b1, 32, 0, "gain_sw");
    check("gain_sw_lit1", 32'd1500);

    step(1'b0, 1'b1, 32, 700, "pre_rst");
    step(1'b0, 1'b1, 32, 800, "pre_rst");
    step(1'b0, 1'b1, 32, 900, "pre_rst");
    step(1'b1, 1'b1, 32, 1000, "mid_rst");
    check("mid_rst_lit", 32'd0);
    step(1'b0, 1'b1, 32, 11, "post_rst");
    step(1'b0, 1'b1, 32, 22, "post_rst");
    check("post_rst_lit1", 32'd0);
    step(1'b0, 1'b1, 32, 33, "post_rst");
    check("post_rst_lit2", 32'd11);

    for (int i = 0; i < 3000; i++) begin
      logic r, v;
      int g, s;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      g = ($urandom_range(0, 3) == 0) ? 32 : int'($urandom_range(0, 2047));
      s = int'($urandom_range(0, 4095)) - 2048;
      step(r, v, g, s, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
